// File: rtl/datapath_controller_if.sv
// datapath_controller_if
//   Bundles every signal between the datapath controller, its instruction
//   source and the register-file/ALU datapath.
//   master modport : the controller (drives ready, RF addresses, ALU controls,
//                    write-back, PSR, done/illegal, FSM state)
//   slave modport  : the environment (instruction source, register file, ALU)
//
//   Handshake: an instruction transfers on a rising edge where instr_valid and
//   instr_ready are both 1. The source keeps instr stable and instr_valid high
//   until that edge. instr_ready depends only on controller state, never
//   combinationally on instr_valid.
interface datapath_controller_if #(
  parameter int BIT_WIDTH      = 16,
  parameter int OPCODE_WIDTH   = 8,
  parameter int FLAG_WIDTH     = 5,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [BIT_WIDTH-1:0]      instr;
  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_a;
  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_b;
  logic [BIT_WIDTH-1:0]      rf_rd_data_a;
  logic [BIT_WIDTH-1:0]      rf_rd_data_b;
  logic [BIT_WIDTH-1:0]      alu_rdest;
  logic [BIT_WIDTH-1:0]      alu_rsrc_imm;
  logic [OPCODE_WIDTH-1:0]   alu_opcode;
  logic [BIT_WIDTH-1:0]      alu_result;
  logic [FLAG_WIDTH-1:0]     alu_flags;
  logic                      rf_wr_en;
  logic [REG_ADDR_WIDTH-1:0] rf_wr_addr;
  logic [BIT_WIDTH-1:0]      rf_wr_data;
  logic [FLAG_WIDTH-1:0]     psr;
  logic                      done;
  logic                      illegal;
  logic [1:0]                state;  // controller FSM state, for observation

  modport master (
    input  instr_valid, instr, rf_rd_data_a, rf_rd_data_b, alu_result, alu_flags,
    output instr_ready, rf_rd_addr_a, rf_rd_addr_b, alu_rdest, alu_rsrc_imm,
           alu_opcode, rf_wr_en, rf_wr_addr, rf_wr_data, psr, done, illegal, state
  );

  modport slave (
    output instr_valid, instr, rf_rd_data_a, rf_rd_data_b, alu_result, alu_flags,
    input  instr_ready, rf_rd_addr_a, rf_rd_addr_b, alu_rdest, alu_rsrc_imm,
           alu_opcode, rf_wr_en, rf_wr_addr, rf_wr_data, psr, done, illegal, state
  );
endinterface

// File: rtl/datapath_controller.sv
// datapath_controller
//   Four-state sequencer (IDLE -> DECODE -> EXECUTE -> WRITEBACK) that takes
//   one 16-bit instruction per handshake, reads operands from the register
//   file, drives the ALU, writes the result back and maintains the PSR.
//   Ports:
//     clk   : sole clock, rising edge
//     reset : synchronous, active-high; aborts any in-flight instruction
//     bus   : datapath_controller_if.master (handshake, RF, ALU, PSR, status)
//   Instruction fields: op=[15:12] rdest=[11:8] ext=[7:4] rsrc=[3:0].
//   PSR / flag order is {C,L,F,Z,N} (bit 4 down to bit 0).
module datapath_controller #(
  parameter int BIT_WIDTH      = 16,
  parameter int OPCODE_WIDTH   = 8,
  parameter int FLAG_WIDTH     = 5,
  parameter int REG_ADDR_WIDTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  datapath_controller_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  // PSR update masks, {C,L,F,Z,N}
  localparam logic [FLAG_WIDTH-1:0] MASK_NONE  = FLAG_WIDTH'(5'b00000);
  localparam logic [FLAG_WIDTH-1:0] MASK_ARITH = FLAG_WIDTH'(5'b10111);
  localparam logic [FLAG_WIDTH-1:0] MASK_UNSGN = FLAG_WIDTH'(5'b11110);
  localparam logic [FLAG_WIDTH-1:0] MASK_CMP   = FLAG_WIDTH'(5'b01011);
  localparam logic [FLAG_WIDTH-1:0] MASK_Z     = FLAG_WIDTH'(5'b00010);

  state_t                state_q, state_next;
  logic [BIT_WIDTH-1:0]  instr_q;
  logic [BIT_WIDTH-1:0]  result_q;
  logic [FLAG_WIDTH-1:0] flags_q;
  logic [FLAG_WIDTH-1:0] psr_q;

  logic [3:0] op, ext;
  assign op  = instr_q[15:12];
  assign ext = instr_q[7:4];

  // Decode of the latched instruction; used in DECODE, EXECUTE and WRITEBACK.
  logic                  dec_legal;
  logic                  dec_imm;
  logic                  dec_write;
  logic [BIT_WIDTH-1:0]  dec_imm_val;
  logic [FLAG_WIDTH-1:0] dec_mask;

  always_comb begin
    dec_legal   = 1'b0;
    dec_imm     = 1'b0;
    dec_write   = 1'b1;
    dec_imm_val = '0;
    dec_mask    = MASK_NONE;
    unique case (op)
      4'b0000: begin
        unique case (ext)
          4'b0000: begin dec_legal = 1'b1; dec_write = 1'b0; end              // NOP
          4'b0001, 4'b0010, 4'b0011, 4'b0100: begin                          // AND/OR/XOR/NOT
            dec_legal = 1'b1; dec_mask = MASK_Z;
          end
          4'b0101, 4'b0111, 4'b1001: begin                                   // ADD/ADDC/SUB
            dec_legal = 1'b1; dec_mask = MASK_ARITH;
          end
          4'b0110: begin dec_legal = 1'b1; dec_mask = MASK_UNSGN; end        // ADDU
          4'b1011: begin                                                     // CMP
            dec_legal = 1'b1; dec_write = 1'b0; dec_mask = MASK_CMP;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      4'b1000: begin
        unique case (ext)
          4'b0100, 4'b0110, 4'b1000, 4'b1001: begin                          // LSH/ARSH/RSH
            dec_legal = 1'b1; dec_mask = MASK_Z;
          end
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1010, 4'b1011: begin        // LSHI/ARSHI/RSHI
            // ext[0] is instr[4], the sign bit of the 5-bit shift amount
            dec_legal   = 1'b1;
            dec_imm     = 1'b1;
            dec_mask    = MASK_Z;
            dec_imm_val = {{(BIT_WIDTH-5){instr_q[4]}}, instr_q[4:0]};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      4'b0101, 4'b0111, 4'b1001: begin                                       // ADDI/ADDCI/SUBI
        dec_legal   = 1'b1;
        dec_imm     = 1'b1;
        dec_mask    = MASK_ARITH;
        dec_imm_val = {{(BIT_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
      end
      4'b1011: begin                                                         // CMPI
        dec_legal   = 1'b1;
        dec_imm     = 1'b1;
        dec_write   = 1'b0;
        dec_mask    = MASK_CMP;
        dec_imm_val = {{(BIT_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
      end
      4'b0110: begin                                                         // ADDUI
        dec_legal   = 1'b1;
        dec_imm     = 1'b1;
        dec_mask    = MASK_UNSGN;
        dec_imm_val = {{(BIT_WIDTH-8){1'b0}}, instr_q[7:0]};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register and datapath latches
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state_q == S_EXECUTE) begin
        result_q <= bus.alu_result;
        flags_q  <= bus.alu_flags;
      end
      // Only the bits this instruction class defines are replaced.
      if (state_q == S_WRITEBACK) psr_q <= (psr_q & ~dec_mask) | (flags_q & dec_mask);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    unique case (state_q)
      S_IDLE:      if (bus.instr_valid) state_next = S_DECODE;
      S_DECODE:    state_next = dec_legal ? S_EXECUTE : S_IDLE;
      S_EXECUTE:   state_next = S_WRITEBACK;
      S_WRITEBACK: state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Outputs: every datapath control is zero outside the state that owns it.
  always_comb begin
    bus.instr_ready  = 1'b0;
    bus.rf_rd_addr_a = '0;
    bus.rf_rd_addr_b = '0;
    bus.alu_rdest    = '0;
    bus.alu_rsrc_imm = '0;
    bus.alu_opcode   = '0;
    bus.rf_wr_en     = 1'b0;
    bus.rf_wr_addr   = '0;
    bus.rf_wr_data   = '0;
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    unique case (state_q)
      S_IDLE: bus.instr_ready = 1'b1;
      S_DECODE: begin
        // Register file returns data one cycle later, i.e. during EXECUTE.
        bus.rf_rd_addr_a = instr_q[11:8];
        bus.rf_rd_addr_b = instr_q[3:0];
        bus.illegal      = ~dec_legal;
      end
      S_EXECUTE: begin
        bus.alu_rdest    = bus.rf_rd_data_a;
        bus.alu_rsrc_imm = dec_imm ? dec_imm_val : bus.rf_rd_data_b;
        bus.alu_opcode   = {op, ext};
      end
      S_WRITEBACK: begin
        bus.rf_wr_en   = dec_write;
        bus.rf_wr_addr = instr_q[11:8];
        bus.rf_wr_data = result_q;
        bus.done       = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.psr   = psr_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  datapath_controller_if #(.BIT_WIDTH(16), .OPCODE_WIDTH(8), .FLAG_WIDTH(5), .REG_ADDR_WIDTH(4)) bus ();

  datapath_controller #(.BIT_WIDTH(16), .OPCODE_WIDTH(8), .FLAG_WIDTH(5), .REG_ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- environment: ALU ----------------
  // Flags {C,L,F,Z,N}: C carry/borrow, L unsigned a<b, F signed overflow,
  // Z zero (equality for CMP), N sign (signed a<b for CMP).
  function automatic logic [20:0] alu_fn(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b);
    logic [3:0]  o, e;
    logic [16:0] sum, dif;
    logic [15:0] r;
    logic c, l, f, z, n;
    int sh;
    o = opc[7:4]; e = opc[3:0];
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    r = 16'h0; c = 1'b0; f = 1'b0;
    l = (a < b);
    sh = int'($signed(b[4:0]));
    if ((o == 4'h0 && (e == 4'h5 || e == 4'h6 || e == 4'h7)) || o == 4'h5 || o == 4'h6 || o == 4'h7) begin
      r = sum[15:0]; c = sum[16]; f = (a[15] == b[15]) && (r[15] != a[15]);
    end else if ((o == 4'h0 && (e == 4'h9 || e == 4'hB)) || o == 4'h9 || o == 4'hB) begin
      r = dif[15:0]; c = dif[16]; f = (a[15] != b[15]) && (r[15] != a[15]);
    end else if (o == 4'h0) begin
      case (e)
        4'h1: r = a & b;
        4'h2: r = a | b;
        4'h3: r = a ^ b;
        4'h4: r = ~b;
        default: r = 16'h0;
      endcase
    end else if (o == 4'h8) begin
      if (e == 4'h4 || e == 4'h0 || e == 4'h1) r = (sh >= 0) ? (a << sh) : (a >> (-sh));
      else if (e == 4'h6 || e == 4'h2 || e == 4'h3) r = $unsigned($signed(a) >>> b[3:0]);
      else r = a >> b[3:0];
    end
    if ((o == 4'h0 && e == 4'hB) || o == 4'hB) begin
      z = (a == b); n = ($signed(a) < $signed(b));
    end else begin
      z = (r == 16'h0); n = r[15];
    end
    return {c, l, f, z, n, r};
  endfunction

  always_comb {bus.alu_flags, bus.alu_result} = alu_fn(bus.alu_opcode, bus.alu_rdest, bus.alu_rsrc_imm);

  // ---------------- environment: register file (registered read) ----------------
  logic [15:0] rf_regs [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = 4'h0;
  logic [15:0] pre_data = 16'h0;

  always @(posedge clk) begin
    bus.rf_rd_data_a <= rf_regs[bus.rf_rd_addr_a];
    bus.rf_rd_data_b <= rf_regs[bus.rf_rd_addr_b];
    if (bus.rf_wr_en) rf_regs[bus.rf_wr_addr] <= bus.rf_wr_data;
    if (pre_en) rf_regs[pre_addr] <= pre_data;
  end

  // ---------------- behavioural model ----------------
  // Instruction classes straight from the ISA tables.
  task automatic mdl_decode(input logic [15:0] w, output logic legal, output logic is_imm,
                            output logic writes, output logic [15:0] imm, output logic [4:0] mask);
    logic [3:0] o, e;
    o = w[15:12]; e = w[7:4];
    legal = 1'b0; is_imm = 1'b0; writes = 1'b1; imm = 16'h0; mask = 5'b00000;
    if (o == 4'h0) begin
      if (e == 4'h0) begin legal = 1'b1; writes = 1'b0; end
      else if (e >= 4'h1 && e <= 4'h4) begin legal = 1'b1; mask = 5'b00010; end
      else if (e == 4'h5 || e == 4'h7 || e == 4'h9) begin legal = 1'b1; mask = 5'b10111; end
      else if (e == 4'h6) begin legal = 1'b1; mask = 5'b11110; end
      else if (e == 4'hB) begin legal = 1'b1; writes = 1'b0; mask = 5'b01011; end
    end else if (o == 4'h8) begin
      if (e == 4'h4 || e == 4'h6 || e == 4'h8 || e == 4'h9) begin legal = 1'b1; mask = 5'b00010; end
      else if (e <= 4'h3 || e == 4'hA || e == 4'hB) begin
        legal = 1'b1; is_imm = 1'b1; mask = 5'b00010; imm = {{11{w[4]}}, w[4:0]};
      end
    end else if (o == 4'h5 || o == 4'h7 || o == 4'h9) begin
      legal = 1'b1; is_imm = 1'b1; mask = 5'b10111; imm = {{8{w[7]}}, w[7:0]};
    end else if (o == 4'hB) begin
      legal = 1'b1; is_imm = 1'b1; writes = 1'b0; mask = 5'b01011; imm = {{8{w[7]}}, w[7:0]};
    end else if (o == 4'h6) begin
      legal = 1'b1; is_imm = 1'b1; mask = 5'b11110; imm = {8'h00, w[7:0]};
    end
  endtask

  // m_cnt: cycles left for the in-flight instruction (0 = ready for a new one).
  logic [15:0] mdl_regs [16];
  int          m_cnt = 0;
  logic        m_legal = 1'b0, m_writes = 1'b0;
  logic [3:0]  m_rd = 4'h0;
  logic [7:0]  m_op8 = 8'h0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0, m_res = 16'h0;
  logic [4:0]  m_flags = 5'h0, m_mask = 5'h0, m_psr = 5'h0;
  logic        started = 1'b0;

  always @(posedge clk) begin : model
    logic lg, im, wr;
    logic [15:0] iv, a, b;
    logic [4:0] mk;
    logic [20:0] fr;
    if (pre_en) mdl_regs[pre_addr] <= pre_data;
    if (reset) begin
      m_cnt   <= 0;
      m_psr   <= 5'h0;
      started <= 1'b1;
    end else begin
      if (m_cnt == 1 && m_legal) begin
        m_psr <= (m_psr & ~m_mask) | (m_flags & m_mask);
        if (m_writes) mdl_regs[m_rd] <= m_res;
      end
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      else if (bus.instr_valid) begin
        mdl_decode(bus.instr, lg, im, wr, iv, mk);
        a  = mdl_regs[bus.instr[11:8]];
        b  = im ? iv : mdl_regs[bus.instr[3:0]];
        fr = alu_fn({bus.instr[15:12], bus.instr[7:4]}, a, b);
        m_legal  <= lg;
        m_writes <= wr;
        m_mask   <= mk;
        m_rd     <= bus.instr[11:8];
        m_op8    <= {bus.instr[15:12], bus.instr[7:4]};
        m_a      <= a;
        m_b      <= b;
        m_flags  <= fr[20:16];
        m_res    <= fr[15:0];
        m_cnt    <= lg ? 3 : 1;
      end
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  int tests = 0;
  int fails = 0;
  int tick_n = 0;
  int done_seen = 0, ill_seen = 0, wr_seen = 0;
  logic [3:0]  last_wr_addr = 4'h0;
  logic [15:0] last_wr_data = 16'h0;
  logic [15:0] exp_q[$];  // expected write data, in retirement order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (tick %0d)", name, act, exp, tick_n);
    end
  endtask

  // One clock: step to the falling edge and compare every output against the model.
  task automatic tick();
    logic e_done, e_ill, e_wr;
    @(negedge clk);
    tick_n++;
    if (started) begin
      e_done = (m_cnt == 1) && m_legal;
      e_ill  = (m_cnt == 1) && !m_legal;
      e_wr   = e_done && m_writes;
      chk("instr_ready", 32'(bus.instr_ready), 32'(m_cnt == 0));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("illegal", 32'(bus.illegal), 32'(e_ill));
      chk("rf_wr_en", 32'(bus.rf_wr_en), 32'(e_wr));
      chk("psr", 32'(bus.psr), 32'(m_psr));
      if (e_wr) begin
        chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(m_rd));
        chk("rf_wr_data", 32'(bus.rf_wr_data), 32'(m_res));
        exp_q.push_back(m_res);
      end
      if (m_cnt == 2 && m_legal) begin
        chk("alu_opcode", 32'(bus.alu_opcode), 32'(m_op8));
        chk("alu_rdest", 32'(bus.alu_rdest), 32'(m_a));
        chk("alu_rsrc_imm", 32'(bus.alu_rsrc_imm), 32'(m_b));
      end
      if (m_cnt == 0) chk("idle_opcode", 32'(bus.alu_opcode), 32'h0);
    end
    if (bus.done === 1'b1) done_seen++;
    if (bus.illegal === 1'b1) ill_seen++;
    if (bus.rf_wr_en === 1'b1) begin
      wr_seen++;
      last_wr_addr = bus.rf_wr_addr;
      last_wr_data = bus.rf_wr_data;
      if (exp_q.size() > 0) chk("wr_order", 32'(bus.rf_wr_data), 32'(exp_q.pop_front()));
      else chk("unexpected_write", 32'(bus.rf_wr_data), 32'hFFFF_FFFF);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  // Offers w and returns the tick at whose following edge it was accepted.
  task automatic send(input logic [15:0] w, output int acc);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.instr_ready === 1'b1) begin
        acc = tick_n;
        break;
      end
      tick();
    end
    if (acc < 0) chk("accept_timeout", 32'h0, 32'h1);
    tick();
  endtask

  task automatic run(input logic [15:0] w);
    int acc;
    send(w, acc);
    bus.instr_valid = 1'b0;
    repeat (5) tick();
  endtask

  logic [15:0] table_vec [14] = '{16'h0718, 16'h0000, 16'h0B2C, 16'h8A48, 16'h8A68, 16'h8A88,
                                  16'h5AF0, 16'h0873, 16'h0893, 16'h08B3, 16'h9C7F, 16'h6D80,
                                  16'h8CA3, 16'h8C2F};
  logic [15:0] illegal_vec [4] = '{16'h0080, 16'h8050, 16'h2000, 16'h8FF0};
  logic [15:0] init_vals [16] = '{16'h0000, 16'h0003, 16'h7FFF, 16'h0001, 16'h0000, 16'h1234,
                                  16'h0034, 16'hF0F0, 16'h0F3C, 16'h8001, 16'h0055, 16'hFFFF,
                                  16'h8421, 16'h00FF, 16'h0002, 16'hA5A5};

  initial begin
    int d0, w0, i0, a1, a2, acc;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) preload(4'(i), init_vals[i]);
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'h1);
    chk("rst_psr", 32'(bus.psr), 32'h0);
    chk("rst_rf_wr_en", 32'(bus.rf_wr_en), 32'h0);
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'h0);

    // ADDI R1,#5 with R1=3 -> R1=8, psr 0
    d0 = done_seen;
    run(16'h5105);
    chk("addi_addr", 32'(last_wr_addr), 32'h1);
    chk("addi_data", 32'(last_wr_data), 32'h8);
    chk("addi_psr", 32'(bus.psr), 32'h00);
    chk("addi_done_once", 32'(done_seen - d0), 32'h1);

    // ADD R2,R3: 7FFF+1 -> 8000, F=1 N=1
    run(16'h0253);
    chk("add_data", 32'(last_wr_data), 32'h8000);
    chk("add_psr", 32'(bus.psr), 32'b00101);

    // CMPI R4,#-1 with R4=0: no write, L=1 Z=0 N=0, C and F held
    w0 = wr_seen;
    run(16'hB4FF);
    chk("cmpi_no_write", 32'(wr_seen - w0), 32'h0);
    chk("cmpi_psr", 32'(bus.psr), 32'b01100);

    // Illegal: pulse on DECODE, ready again two cycles after accept
    w0 = wr_seen; i0 = ill_seen;
    send(16'hF000, acc);
    bus.instr_valid = 1'b0;
    tick();
    chk("ill_ready_back", 32'(bus.instr_ready), 32'h1);
    repeat (3) tick();
    chk("ill_pulse", 32'(ill_seen - i0), 32'h1);
    chk("ill_no_write", 32'(wr_seen - w0), 32'h0);
    chk("ill_psr", 32'(bus.psr), 32'b01100);

    // Back-to-back ADDUI R1,#FF then LSHI R1,#-2 (16'h811E encodes -2)
    send(16'h61FF, a1);
    send(16'h811E, a2);
    bus.instr_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_spacing", 32'(a2 - a1), 32'h4);
    chk("b2b_lshi_data", 32'(last_wr_data), 32'h0041);
    chk("b2b_psr", 32'(bus.psr), 32'b01000);

    // Reset during EXECUTE of SUB R5,R6
    d0 = done_seen; w0 = wr_seen;
    send(16'h0596, acc);
    bus.instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_ready", 32'(bus.instr_ready), 32'h1);
    chk("rst_mid_psr", 32'(bus.psr), 32'h0);
    repeat (5) tick();
    chk("rst_mid_no_done", 32'(done_seen - d0), 32'h0);
    chk("rst_mid_no_write", 32'(wr_seen - w0), 32'h0);

    // Sweep of the remaining forms and illegal encodings, checked cycle by cycle
    for (int i = 0; i < 14; i++) run(table_vec[i]);
    i0 = ill_seen;
    for (int i = 0; i < 4; i++) run(illegal_vec[i]);
    chk("ill_sweep_count", 32'(ill_seen - i0), 32'h4);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
